// File: rtl/snitch_icache_pkg.sv
// Shared types for the instruction-cache tag controller: cache geometry,
// controller FSM states and a small index-width helper.
package snitch_icache_pkg;

   // Cache geometry. COUNT_ALIGN is the line-index width (log2 LINE_COUNT).
   typedef struct packed {
      int unsigned WAY_COUNT;
      int unsigned LINE_COUNT;
      int unsigned COUNT_ALIGN;
      int unsigned TAG_WIDTH;
   } config_t;

   localparam config_t DefaultCfg = '{
      WAY_COUNT:   4,
      LINE_COUNT:  8,
      COUNT_ALIGN: 3,
      TAG_WIDTH:   10
   };

   // Controller states: INIT clears the array after reset, FLUSH clears it on request.
   typedef enum logic [1:0] {
      StInit,
      StIdle,
      StFlush
   } ctrl_state_e;

   // Width of an index into n items, never below one bit.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/snitch_icache_tag_cmp.sv
// Combinational tag compare across all ways of one line, plus one-hot hit-way
// and replacement-victim selection.
module snitch_icache_tag_cmp
   import snitch_icache_pkg::*;
#(
   parameter config_t CFG = DefaultCfg
) (
   input  logic [CFG.WAY_COUNT-1:0][CFG.TAG_WIDTH+1:0] rtag_i,
   input  logic [CFG.TAG_WIDTH-1:0]                    tag_i,
   input  logic [idx_width(CFG.WAY_COUNT)-1:0]         rr_i,
   output logic                                        hit_o,
   output logic [CFG.WAY_COUNT-1:0]                    way_o,
   output logic                                        error_o,
   output logic [CFG.WAY_COUNT-1:0]                    victim_o,
   output logic                                        all_valid_o
);

   localparam int unsigned WayCount = CFG.WAY_COUNT;
   localparam int unsigned TagWidth = CFG.TAG_WIDTH;

   typedef struct packed {
      logic                valid;
      logic                error;
      logic [TagWidth-1:0] tag;
   } tag_entry_t;

   tag_entry_t entry;
   logic       found_invalid;

   // Lowest-index match wins; victim is lowest invalid way, else the round-robin way.
   always_comb begin
      hit_o         = 1'b0;
      way_o         = '0;
      error_o       = 1'b0;
      victim_o      = '0;
      all_valid_o   = 1'b1;
      found_invalid = 1'b0;
      entry         = '0;
      for (int unsigned i = 0; i < WayCount; i++) begin
         entry = rtag_i[i];
         if (entry.valid && (entry.tag == tag_i) && !hit_o) begin
            hit_o    = 1'b1;
            way_o[i] = 1'b1;
            error_o  = entry.error;
         end
         if (!entry.valid) begin
            all_valid_o = 1'b0;
            if (!found_invalid) begin
               victim_o[i]   = 1'b1;
               found_invalid = 1'b1;
            end
         end
      end
      if (all_valid_o) begin
         victim_o = WayCount'(1) << rr_i;
      end
   end

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag SRAM sequencer/arbiter: clears the array after reset and on flush, and
// shares the single SRAM port between refill writes and lookups. Lookup
// results appear one cycle after acceptance and are held while stalled.
module snitch_icache_tag_ctrl
   import snitch_icache_pkg::*;
#(
   parameter config_t CFG = DefaultCfg
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        flush_valid_i,
   output logic                                        flush_ready_o,
   input  logic                                        lookup_valid_i,
   output logic                                        lookup_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]                  lookup_addr_i,
   input  logic [CFG.TAG_WIDTH-1:0]                    lookup_tag_i,
   output logic                                        rsp_valid_o,
   input  logic                                        rsp_ready_i,
   output logic                                        rsp_hit_o,
   output logic [CFG.WAY_COUNT-1:0]                    rsp_way_o,
   output logic                                        rsp_error_o,
   output logic [CFG.WAY_COUNT-1:0]                    rsp_victim_o,
   input  logic                                        write_valid_i,
   output logic                                        write_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]                  write_addr_i,
   input  logic [CFG.WAY_COUNT-1:0]                    write_way_i,
   input  logic [CFG.TAG_WIDTH-1:0]                    write_tag_i,
   input  logic                                        write_error_i,
   output logic [CFG.WAY_COUNT-1:0]                    ram_enable_o,
   output logic                                        ram_write_o,
   output logic [CFG.COUNT_ALIGN-1:0]                  ram_addr_o,
   output logic [CFG.TAG_WIDTH+1:0]                    ram_wtag_o,
   input  logic [CFG.WAY_COUNT-1:0][CFG.TAG_WIDTH+1:0] ram_rtag_i
);

   localparam int unsigned WayCount   = CFG.WAY_COUNT;
   localparam int unsigned LineCount  = CFG.LINE_COUNT;
   localparam int unsigned CountAlign = CFG.COUNT_ALIGN;
   localparam int unsigned TagWidth   = CFG.TAG_WIDTH;
   localparam int unsigned RrWidth    = idx_width(WayCount);

   localparam logic [CountAlign-1:0] LastLine = CountAlign'(LineCount - 1);
   localparam logic [RrWidth-1:0]    LastWay  = RrWidth'(WayCount - 1);

   ctrl_state_e           state_q, state_d;
   logic [CountAlign-1:0] cnt_q, cnt_d;
   logic [RrWidth-1:0]    rr_q, rr_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [TagWidth-1:0]   tag_q, tag_d;

   logic                  hold_valid_q, hold_valid_d;
   logic                  hold_hit_q, hold_hit_d;
   logic                  hold_error_q, hold_error_d;
   logic                  hold_all_valid_q, hold_all_valid_d;
   logic [WayCount-1:0]   hold_way_q, hold_way_d;
   logic [WayCount-1:0]   hold_victim_q, hold_victim_d;

   logic                  cmp_hit, cmp_error, cmp_all_valid;
   logic [WayCount-1:0]   cmp_way, cmp_victim;

   logic                  idle, lookup_hs, write_hs, flush_go, rsp_hs, rsp_all_valid;

   snitch_icache_tag_cmp #(
      .CFG (CFG)
   ) i_tag_cmp (
      .rtag_i      (ram_rtag_i),
      .tag_i       (tag_q),
      .rr_i        (rr_q),
      .hit_o       (cmp_hit),
      .way_o       (cmp_way),
      .error_o     (cmp_error),
      .victim_o    (cmp_victim),
      .all_valid_o (cmp_all_valid)
   );

   // Response mux: live compare in the cycle after acceptance, hold register when stalled.
   always_comb begin
      rsp_valid_o   = rd_pending_q | hold_valid_q;
      rsp_hit_o     = 1'b0;
      rsp_way_o     = '0;
      rsp_error_o   = 1'b0;
      rsp_victim_o  = '0;
      rsp_all_valid = 1'b0;
      if (rd_pending_q) begin
         rsp_hit_o     = cmp_hit;
         rsp_way_o     = cmp_way;
         rsp_error_o   = cmp_error;
         rsp_victim_o  = cmp_victim;
         rsp_all_valid = cmp_all_valid;
      end else if (hold_valid_q) begin
         rsp_hit_o     = hold_hit_q;
         rsp_way_o     = hold_way_q;
         rsp_error_o   = hold_error_q;
         rsp_victim_o  = hold_victim_q;
         rsp_all_valid = hold_all_valid_q;
      end
   end

   // Port arbitration: flush beats write beats lookup, but a flush never
   // overlaps an outstanding or freshly accepted lookup.
   always_comb begin
      idle           = (state_q == StIdle);
      rsp_hs         = rsp_valid_o & rsp_ready_i;
      lookup_ready_o = idle & ~write_valid_i & (~rsp_valid_o | rsp_ready_i);
      lookup_hs      = lookup_valid_i & lookup_ready_o;
      flush_go       = idle & flush_valid_i & ~rsp_valid_o & ~lookup_hs;
      write_ready_o  = idle & ~flush_go;
      write_hs       = write_valid_i & write_ready_o;
   end

   // FSM next state and sweep counter.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      flush_ready_o = 1'b0;
      unique case (state_q)
         StInit, StFlush: begin
            if (cnt_q == LastLine) begin
               state_d       = StIdle;
               cnt_d         = '0;
               flush_ready_o = (state_q == StFlush);
            end else begin
               cnt_d = cnt_q + CountAlign'(1);
            end
         end
         StIdle: begin
            if (flush_go) begin
               state_d = StFlush;
            end
         end
         default: state_d = StInit;
      endcase
   end

   // SRAM request generation.
   always_comb begin
      ram_enable_o = '0;
      ram_write_o  = 1'b0;
      ram_addr_o   = '0;
      ram_wtag_o   = '0;
      unique case (state_q)
         StInit, StFlush: begin
            ram_enable_o = '1;
            ram_write_o  = 1'b1;
            ram_addr_o   = cnt_q;
         end
         StIdle: begin
            if (write_hs) begin
               ram_enable_o = write_way_i;
               ram_write_o  = 1'b1;
               ram_addr_o   = write_addr_i;
               ram_wtag_o   = {1'b1, write_error_i, write_tag_i};
            end else if (lookup_hs) begin
               ram_enable_o = '1;
               ram_addr_o   = lookup_addr_i;
            end
         end
         default: ;
      endcase
   end

   // Lookup pipeline, hold register and round-robin victim pointer.
   always_comb begin
      rd_pending_d     = lookup_hs;
      tag_d            = lookup_hs ? lookup_tag_i : tag_q;
      hold_valid_d     = hold_valid_q;
      hold_hit_d       = hold_hit_q;
      hold_error_d     = hold_error_q;
      hold_all_valid_d = hold_all_valid_q;
      hold_way_d       = hold_way_q;
      hold_victim_d    = hold_victim_q;
      rr_d             = rr_q;
      if (rd_pending_q && !rsp_ready_i) begin
         hold_valid_d     = 1'b1;
         hold_hit_d       = cmp_hit;
         hold_error_d     = cmp_error;
         hold_all_valid_d = cmp_all_valid;
         hold_way_d       = cmp_way;
         hold_victim_d    = cmp_victim;
      end else if (hold_valid_q && rsp_ready_i) begin
         hold_valid_d = 1'b0;
      end
      // Only a consumed miss on a full line actually evicts the rr way.
      if (rsp_hs && !rsp_hit_o && rsp_all_valid) begin
         rr_d = (rr_q == LastWay) ? '0 : rr_q + RrWidth'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= StInit;
         cnt_q            <= '0;
         rr_q             <= '0;
         rd_pending_q     <= 1'b0;
         tag_q            <= '0;
         hold_valid_q     <= 1'b0;
         hold_hit_q       <= 1'b0;
         hold_error_q     <= 1'b0;
         hold_all_valid_q <= 1'b0;
         hold_way_q       <= '0;
         hold_victim_q    <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         rr_q             <= rr_d;
         rd_pending_q     <= rd_pending_d;
         tag_q            <= tag_d;
         hold_valid_q     <= hold_valid_d;
         hold_hit_q       <= hold_hit_d;
         hold_error_q     <= hold_error_d;
         hold_all_valid_q <= hold_all_valid_d;
         hold_way_q       <= hold_way_d;
         hold_victim_q    <= hold_victim_d;
      end
   end

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Directed bench for snitch_icache_tag_ctrl (4 ways, 8 lines, 10-bit tags)
// with a behavioural 1-cycle-latency tag SRAM.
module tb_snitch_icache_tag_ctrl;
   import snitch_icache_pkg::*;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             flush_valid, flush_ready;
   logic             lookup_valid, lookup_ready;
   logic [2:0]       lookup_addr;
   logic [9:0]       lookup_tag;
   logic             rsp_valid, rsp_ready, rsp_hit, rsp_error;
   logic [3:0]       rsp_way, rsp_victim;
   logic             write_valid, write_ready, write_error;
   logic [2:0]       write_addr;
   logic [3:0]       write_way;
   logic [9:0]       write_tag;
   logic [3:0]       ram_enable;
   logic             ram_write;
   logic [2:0]       ram_addr;
   logic [11:0]      ram_wtag;
   logic [3:0][11:0] ram_rtag;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   snitch_icache_tag_ctrl #(
      .CFG (DefaultCfg)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .flush_valid_i  (flush_valid),
      .flush_ready_o  (flush_ready),
      .lookup_valid_i (lookup_valid),
      .lookup_ready_o (lookup_ready),
      .lookup_addr_i  (lookup_addr),
      .lookup_tag_i   (lookup_tag),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_hit_o      (rsp_hit),
      .rsp_way_o      (rsp_way),
      .rsp_error_o    (rsp_error),
      .rsp_victim_o   (rsp_victim),
      .write_valid_i  (write_valid),
      .write_ready_o  (write_ready),
      .write_addr_i   (write_addr),
      .write_way_i    (write_way),
      .write_tag_i    (write_tag),
      .write_error_i  (write_error),
      .ram_enable_o   (ram_enable),
      .ram_write_o    (ram_write),
      .ram_addr_o     (ram_addr),
      .ram_wtag_o     (ram_wtag),
      .ram_rtag_i     (ram_rtag)
   );

   // Tag SRAM model, preloaded with junk so the clearing sweep matters.
   logic [11:0] mem [4][8];
   initial begin
      for (int w = 0; w < 4; w++) for (int l = 0; l < 8; l++) mem[w][l] = 12'hFFF;
      ram_rtag = '0;
   end
   always @(posedge clk) begin
      for (int w = 0; w < 4; w++) begin
         if (ram_enable[w]) begin
            if (ram_write) mem[w][ram_addr] <= ram_wtag;
            else           ram_rtag[w]      <= mem[w][ram_addr];
         end
      end
   end

   typedef struct packed {
      logic fv; logic lv; logic [2:0] la; logic [9:0] lt; logic rr;
      logic wv; logic [2:0] wa; logic [3:0] ww; logic [9:0] wt; logic we;
   } in_t;

   typedef struct packed {
      logic lrdy; logic wrdy; logic rv; logic hit; logic [3:0] way; logic err;
      logic [3:0] vic; logic [3:0] en; logic wr; logic [2:0] addr; logic [11:0] wtag;
      logic frdy;
   } ex_t;

   typedef struct {
      string name;
      in_t   i;
      ex_t   e;
   } vec_t;

   function automatic in_t i_nop(logic rr, logic fv);
      in_t r = '0;
      r.rr = rr; r.fv = fv;
      return r;
   endfunction

   function automatic in_t i_wr(logic [2:0] a, logic [3:0] w, logic [9:0] t, logic e);
      in_t r = '0;
      r.wv = 1'b1; r.wa = a; r.ww = w; r.wt = t; r.we = e; r.rr = 1'b1;
      return r;
   endfunction

   function automatic in_t i_lk(logic [2:0] a, logic [9:0] t, logic rr);
      in_t r = '0;
      r.lv = 1'b1; r.la = a; r.lt = t; r.rr = rr;
      return r;
   endfunction

   function automatic in_t with_fv(in_t x);
      x.fv = 1'b1;
      return x;
   endfunction

   function automatic ex_t e_nop();
      ex_t r = '0;
      r.lrdy = 1'b1; r.wrdy = 1'b1;
      return r;
   endfunction

   function automatic ex_t e_wr(logic [2:0] a, logic [3:0] w, logic [11:0] wtag);
      ex_t r = '0;
      r.wrdy = 1'b1; r.en = w; r.wr = 1'b1; r.addr = a; r.wtag = wtag;
      return r;
   endfunction

   function automatic ex_t e_lk(logic [2:0] a);
      ex_t r = '0;
      r.lrdy = 1'b1; r.wrdy = 1'b1; r.en = 4'hF; r.addr = a;
      return r;
   endfunction

   function automatic ex_t e_sweep(logic [2:0] a, logic frdy);
      ex_t r = '0;
      r.en = 4'hF; r.wr = 1'b1; r.addr = a; r.frdy = frdy;
      return r;
   endfunction

   function automatic ex_t rsp(ex_t b, logic hit, logic [3:0] way, logic err, logic [3:0] vic);
      b.rv = 1'b1; b.hit = hit; b.way = way; b.err = err; b.vic = vic;
      return b;
   endfunction

   function automatic ex_t no_lrdy(ex_t b);
      b.lrdy = 1'b0;
      return b;
   endfunction

   function automatic ex_t no_wrdy(ex_t b);
      b.wrdy = 1'b0;
      return b;
   endfunction

   function automatic vec_t mk(string name, in_t i, ex_t e);
      vec_t v;
      v.name = name; v.i = i; v.e = e;
      return v;
   endfunction

   task automatic drive(input in_t i);
      flush_valid  = i.fv;
      lookup_valid = i.lv;
      lookup_addr  = i.la;
      lookup_tag   = i.lt;
      rsp_ready    = i.rr;
      write_valid  = i.wv;
      write_addr   = i.wa;
      write_way    = i.ww;
      write_tag    = i.wt;
      write_error  = i.we;
   endtask

   task automatic check(input string name, input ex_t e);
      ex_t a;
      a = '{lookup_ready, write_ready, rsp_valid, rsp_hit, rsp_way, rsp_error, rsp_victim,
            ram_enable, ram_write, ram_addr, ram_wtag, flush_ready};
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (lrdy wrdy rv hit way err vic en wr addr wtag frdy)",
                  name, a, e);
      end
   endtask

   // One cycle: drive away from the edge, let it settle, compare.
   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v.i);
      #1;
      check(v.name, v.e);
   endtask

   task automatic sweep_checks(input string name, input int first, input int last, input int fl);
      for (int l = first; l <= last; l++) begin
         @(negedge clk);
         #1;
         check(name, e_sweep(3'(l), (fl != 0) && (l == 7)));
      end
   endtask

   vec_t tbl[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0;
      drive(i_nop(1'b1, 1'b0));

      // Reset and post-reset clearing sweep.
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", e_sweep(3'd0, 1'b0));
      rst_ni = 1'b1;
      #1;
      check("init_line0", e_sweep(3'd0, 1'b0));
      sweep_checks("init_sweep", 1, 7, 0);
      @(negedge clk);
      #1;
      check("idle_after_init", e_nop());

      // Main function table.
      tbl.push_back(mk("wr_l3_w2", i_wr(3, 4'b0100, 10'h155, 0), e_wr(3, 4'b0100, 12'h955)));
      tbl.push_back(mk("lk_l3_155", i_lk(3, 10'h155, 1), e_lk(3)));
      tbl.push_back(mk("rsp_hit_w2", i_nop(1, 0), rsp(e_nop(), 1, 4'b0100, 0, 4'b0001)));
      tbl.push_back(mk("wr_l3_w0_err", i_wr(3, 4'b0001, 10'h2A5, 1), e_wr(3, 4'b0001, 12'hEA5)));
      tbl.push_back(mk("lk_l3_2a5", i_lk(3, 10'h2A5, 1), e_lk(3)));
      tbl.push_back(mk("rsp_hit_err_b2b", i_lk(3, 10'h155, 1),
                       rsp(e_lk(3), 1, 4'b0001, 1, 4'b0010)));
      tbl.push_back(mk("rsp_hit_w2_b2b", i_nop(1, 0), rsp(e_nop(), 1, 4'b0100, 0, 4'b0010)));
      tbl.push_back(mk("wr_l5_w0", i_wr(5, 4'b0001, 10'h011, 0), e_wr(5, 4'b0001, 12'h811)));
      tbl.push_back(mk("wr_l5_w1", i_wr(5, 4'b0010, 10'h022, 0), e_wr(5, 4'b0010, 12'h822)));
      tbl.push_back(mk("lk_l5_0aa", i_lk(5, 10'h0AA, 1), e_lk(5)));
      tbl.push_back(mk("rsp_miss_inv", i_nop(1, 0), rsp(e_nop(), 0, 4'b0000, 0, 4'b0100)));
      tbl.push_back(mk("wr_l5_w2_dup", i_wr(5, 4'b0100, 10'h022, 0), e_wr(5, 4'b0100, 12'h822)));
      tbl.push_back(mk("wr_l5_w3", i_wr(5, 4'b1000, 10'h033, 0), e_wr(5, 4'b1000, 12'h833)));
      tbl.push_back(mk("lk_l5_022", i_lk(5, 10'h022, 1), e_lk(5)));
      tbl.push_back(mk("rsp_multihit", i_nop(1, 0), rsp(e_nop(), 1, 4'b0010, 0, 4'b0001)));
      tbl.push_back(mk("lk_l5_3ff", i_lk(5, 10'h3FF, 1), e_lk(5)));
      tbl.push_back(mk("rsp_miss_rr0", i_lk(5, 10'h3FE, 1), rsp(e_lk(5), 0, 4'b0000, 0, 4'b0001)));
      tbl.push_back(mk("rsp_miss_rr1", i_lk(5, 10'h100, 1), rsp(e_lk(5), 0, 4'b0000, 0, 4'b0010)));
      tbl.push_back(mk("rsp_miss_rr2", i_nop(1, 0), rsp(e_nop(), 0, 4'b0000, 0, 4'b0100)));
      foreach (tbl[k]) apply(tbl[k]);

      // Stalled response: held stable, no new lookup, no SRAM access.
      apply(mk("stall_lk", i_lk(3, 10'h155, 1), e_lk(3)));
      for (int s = 0; s < 3; s++) begin
         apply(mk("stall_hold", i_lk(3, 10'h2A5, 0),
                  rsp(no_lrdy(e_nop()), 1, 4'b0100, 0, 4'b0010)));
      end
      apply(mk("stall_release", i_nop(1, 0), rsp(e_nop(), 1, 4'b0100, 0, 4'b0010)));
      apply(mk("stall_done", i_nop(1, 0), e_nop()));

      // Flush waits for the pending response, then clears every line.
      apply(mk("flush_with_lk", with_fv(i_lk(3, 10'h155, 1)), e_lk(3)));
      apply(mk("flush_wait_rsp", i_nop(0, 1), rsp(no_lrdy(e_nop()), 1, 4'b0100, 0, 4'b0010)));
      apply(mk("flush_wait_hs", i_nop(1, 1), rsp(e_nop(), 1, 4'b0100, 0, 4'b0010)));
      apply(mk("flush_start", i_nop(1, 1), no_wrdy(e_nop())));
      for (int l = 0; l < 8; l++) begin
         apply(mk("flush_sweep", i_nop(1, 1), e_sweep(3'(l), l == 7)));
      end
      apply(mk("flush_idle", i_nop(1, 0), e_nop()));
      apply(mk("post_flush_lk", i_lk(3, 10'h155, 1), e_lk(3)));
      apply(mk("post_flush_miss", i_nop(1, 0), rsp(e_nop(), 0, 4'b0000, 0, 4'b0001)));

      // Async reset with a response pending, then again mid-sweep at line 5.
      apply(mk("rst_lk", i_lk(5, 10'h011, 1), e_lk(5)));
      apply(mk("rst_pending", i_nop(0, 0), rsp(no_lrdy(e_nop()), 0, 4'b0000, 0, 4'b0001)));
      rst_ni = 1'b0;
      #1;
      check("rst_drops_rsp", e_sweep(3'd0, 1'b0));
      @(negedge clk);
      #1;
      check("rst_held", e_sweep(3'd0, 1'b0));
      rst_ni = 1'b1;
      #1;
      check("rst_release", e_sweep(3'd0, 1'b0));
      sweep_checks("resweep_a", 1, 5, 0);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_sweep", e_sweep(3'd0, 1'b0));
      @(negedge clk);
      #1;
      check("rst_mid_held", e_sweep(3'd0, 1'b0));
      rst_ni = 1'b1;
      #1;
      check("rst_mid_release", e_sweep(3'd0, 1'b0));
      sweep_checks("resweep_b", 1, 7, 0);
      @(negedge clk);
      #1;
      check("idle_after_resweep", e_nop());

      // Full line after reset: rr must have restarted from way 0.
      apply(mk("rr_fill_w0", i_wr(5, 4'b0001, 10'h011, 0), e_wr(5, 4'b0001, 12'h811)));
      apply(mk("rr_fill_w1", i_wr(5, 4'b0010, 10'h022, 0), e_wr(5, 4'b0010, 12'h822)));
      apply(mk("rr_fill_w2", i_wr(5, 4'b0100, 10'h033, 0), e_wr(5, 4'b0100, 12'h833)));
      apply(mk("rr_fill_w3", i_wr(5, 4'b1000, 10'h044, 0), e_wr(5, 4'b1000, 12'h844)));
      apply(mk("rr_lk", i_lk(5, 10'h055, 1), e_lk(5)));
      apply(mk("rr_reset_victim", i_nop(1, 0), rsp(e_nop(), 0, 4'b0000, 0, 4'b0001)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
